// File: rtl/mpram_async_if.sv
// Bundles the read, write and clear signals of mpram_async; the master drives addresses, write data and requests.
interface mpram_async_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2
);
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RPORTS-1:0]            re;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH-1:0]            waddr;
  logic                             we;
  logic [DATA_WIDTH/8-1:0]          wbe;
  logic [DATA_WIDTH-1:0]            din;
  logic                             clr_req;
  logic                             busy;

  modport master (
    output raddr, re, waddr, we, wbe, din, clr_req,
    input  dout, busy
  );

  modport slave (
    input  raddr, re, waddr, we, wbe, din, clr_req,
    output dout, busy
  );
endinterface

// File: rtl/mpram_async.sv
// Multi-read-port RAM with zero-latency reads, optional same-cycle write bypass and one-edge byte-masked writes.
// No backpressure: user writes arriving while the clear sweep runs (busy=1) are silently dropped.
module mpram_async #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RPORTS    = 2,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  mpram_async_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                           state;
  logic [ADDR_WIDTH-1:0]            clr_ptr;
  logic                             busy_q;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_all;
  logic [ADDR_WIDTH-1:0]            ra;
  logic [DATA_WIDTH-1:0]            rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req is deliberately ignored here so an active sweep never restarts
          clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
          if (&clr_ptr) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= CLEAR;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset: zeroing happens only through the sweep, and never while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (state == IDLE && bus.we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wbe[b]) begin
          mem[bus.waddr][8*b +: 8] <= bus.din[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    dout_all = '0;
    ra       = '0;
    rd       = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd = mem[ra];
      if (ENABLE_BYPASS != 0 && bus.we && bus.waddr == ra) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wbe[b]) begin
            rd[8*b +: 8] = bus.din[8*b +: 8];
          end
        end
      end
      if (!bus.re[i] || busy_q) begin
        rd = '0;
      end
      dout_all[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    end
  end

  assign bus.dout = dout_all;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_mpram_async.sv
// Drives a bypass and a no-bypass mpram_async in lockstep and scoreboards their read ports against a reference array.
module tb_mpram_async;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpram_async_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(2)) b ();
  mpram_async_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(2)) n ();

  assign n.raddr   = b.raddr;
  assign n.re      = b.re;
  assign n.waddr   = b.waddr;
  assign n.we      = b.we;
  assign n.wbe     = b.wbe;
  assign n.din     = b.din;
  assign n.clr_req = b.clr_req;

  mpram_async #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(2), .ENABLE_BYPASS(1))
    dut (.clk(clk), .rst(rst), .bus(b));
  mpram_async #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RPORTS(2), .ENABLE_BYPASS(0))
    dut_nb (.clk(clk), .rst(rst), .bus(n));

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model [32];
  logic [31:0] obs;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] rd_port(int inst, int port);
    logic [63:0] d;
    d = (inst == 0) ? b.dout : n.dout;
    return d[port*32 +: 32];
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic push_both(int port, logic [31:0] v);
    sb.push_back('{0, port, v});
    sb.push_back('{1, port, v});
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    b.we = 1'b1; b.waddr = a; b.din = d; b.wbe = be;
    @(posedge clk);
    model[a] = merge(model[a], d, be);
    #1 b.we = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    b.re = 2'b11; b.raddr = 10'd0; b.we = 1'b0; b.waddr = '0; b.wbe = '0;
    b.din = '0; b.clr_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (b.busy !== 1'b1 || n.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b/%b want 1", b.busy, n.busy);
    end
    push_both(0, 32'h0); push_both(1, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL reset_dout inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      cnt = k;
      if (!b.busy) break;
    end
    checks++;
    if (cnt !== 32) begin
      errors++; $display("FAIL reset_clear_len got %0d edges want 32", cnt);
    end
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      b.raddr = {5'(31 - a), 5'(a)};
      push_both(0, model[a]); push_both(1, model[31 - a]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
        if (obs !== e.val) begin
          errors++; $display("FAIL reset_zero addr%0d inst%0d port%0d got %h want %h", a, e.inst, e.port, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    wr(5'd3, 32'hDEADBEEF, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    @(negedge clk);
    b.re = 2'b11; b.raddr = {5'd0, 5'd3};
    push_both(0, 32'hDE22BE44);
    push_both(1, model[0]);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL byte_write inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h01020304, 4'b1111);
    wr(5'd8, 32'h00000808, 4'b1111);
    @(negedge clk);
    b.we = 1'b1; b.waddr = 5'd7; b.din = 32'hA5A5A5A5; b.wbe = 4'b1100;
    b.re = 2'b11; b.raddr = {5'd8, 5'd7};
    sb.push_back('{0, 0, 32'hA5A50304});
    sb.push_back('{1, 0, 32'h01020304});
    push_both(1, 32'h00000808);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL bypass inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
    @(posedge clk);
    model[7] = merge(model[7], 32'hA5A5A5A5, 4'b1100);
    #1 b.we = 1'b0;
    @(negedge clk);
    push_both(0, 32'hA5A50304);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL bypass_commit inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    wr(5'd9, 32'h00000055, 4'b0001);
    @(negedge clk);
    b.re = 2'b11; b.raddr = {5'd9, 5'd9};
    push_both(0, 32'h55); push_both(1, 32'h55);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL clear_pre inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
    b.clr_req = 1'b1;
    @(posedge clk);
    #1 b.clr_req = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      b.we = (k == 1 || k == 20); b.waddr = 5'd9; b.din = 32'hFFFFFFFF; b.wbe = 4'hF;
      b.clr_req = (k == 10);
      if (k == 1 || k == 20) begin
        #1;
        checks++;
        if (b.dout !== 64'h0 || n.dout !== 64'h0 || b.busy !== 1'b1) begin
          errors++; $display("FAIL clear_busy_read k=%0d got %h/%h busy=%b want 0 busy=1", k, b.dout, n.dout, b.busy);
        end
      end
      @(posedge clk); #1;
      cnt = k;
      if (!b.busy) break;
    end
    b.we = 1'b0; b.clr_req = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    checks++;
    if (cnt !== 32) begin
      errors++; $display("FAIL clear_len got %0d edges want 32", cnt);
    end
    @(negedge clk);
    push_both(0, model[9]); push_both(1, model[9]);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
      if (obs !== e.val) begin
        errors++; $display("FAIL clear_addr9 inst%0d port%0d got %h want %h", e.inst, e.port, obs, e.val);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    for (int a = 20; a < 26; a++) wr(5'(a), 32'h1000_0000 + 32'(a), 4'hF);
    @(negedge clk) b.clr_req = 1'b1;
    @(posedge clk);
    #1 b.clr_req = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (b.busy !== 1'b1 || b.dout !== 64'h0) begin
      errors++; $display("FAIL midrst_assert got busy=%b dout=%h want 1/0", b.busy, b.dout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      cnt = k;
      if (!b.busy) break;
    end
    checks++;
    if (cnt !== 32) begin
      errors++; $display("FAIL midrst_len got %0d edges want 32", cnt);
    end
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      b.re = 2'b11; b.raddr = {5'(a), 5'(a)};
      push_both(0, model[a]); push_both(1, model[a]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
        if (obs !== e.val) begin
          errors++; $display("FAIL midrst_zero addr%0d inst%0d port%0d got %h want %h", a, e.inst, e.port, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_read_enable();
    wr(5'd12, 32'hCAFEF00D, 4'hF);
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      b.raddr = {5'd12, 5'd12};
      b.re = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : 2'b00;
      push_both(0, b.re[0] ? 32'hCAFEF00D : 32'h0);
      push_both(1, b.re[1] ? 32'hCAFEF00D : 32'h0);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
        if (obs !== e.val) begin
          errors++; $display("FAIL read_enable re=%b inst%0d port%0d got %h want %h", b.re, e.inst, e.port, obs, e.val);
        end
      end
    end
    b.re = 2'b11;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [3:0]  be;
    for (int k = 1; k <= 20; k++) begin
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      @(negedge clk);
      b.we = 1'b1; b.waddr = 5'(k); b.din = d; b.wbe = be;
      b.re = 2'b11; b.raddr = {5'(k - 1), 5'(k)};
      sb.push_back('{0, 0, merge(model[k], d, be)});
      sb.push_back('{1, 0, model[k]});
      push_both(1, model[k - 1]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = rd_port(e.inst, e.port); checks++;
        if (obs !== e.val) begin
          errors++; $display("FAIL back_to_back k=%0d inst%0d port%0d got %h want %h", k, e.inst, e.port, obs, e.val);
        end
      end
      @(posedge clk);
      model[k] = merge(model[k], d, be);
    end
    #1 b.we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_bypass();
    test_clear();
    test_reset_mid();
    test_read_enable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
